// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipelined_addsub_if
// Brief   : valid/ready operand and result bundle for pipelined_addsub
// Rev     : 1.0
// ----------------------------------------------------------------------------
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipelined_addsub
// Brief   : chunked, carry-pipelined two's-complement adder/subtractor
// Rev     : 1.0
// ----------------------------------------------------------------------------
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic w_en;

    // Stage k adds chunk k; operand bits not yet consumed ride along in a_q/b_q,
    // finished sum bits accumulate in s_q.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]    w_a_src;
        logic [RW-1:0]    w_b_src;
        logic             w_c_src;
        logic             w_v_src;
        logic [CW:0]      w_chunk;
        logic [LO+CW-1:0] s_d;
        logic [LO+CW-1:0] s_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign w_a_src = bus.a;
            assign w_b_src = bus.sub ? ~bus.b : bus.b;
            assign w_c_src = bus.sub | bus.cin;
            assign w_v_src = bus.in_valid;
            assign s_d     = w_chunk[CW-1:0];
        end else begin : g_body
            assign w_a_src = g_stage[k-1].g_fwd.a_q;
            assign w_b_src = g_stage[k-1].g_fwd.b_q;
            assign w_c_src = g_stage[k-1].c_q;
            assign w_v_src = g_stage[k-1].v_q;
            assign s_d     = {w_chunk[CW-1:0], g_stage[k-1].s_q};
        end

        assign w_chunk = {1'b0, w_a_src[CW-1:0]} + {1'b0, w_b_src[CW-1:0]}
                       + {{CW{1'b0}}, w_c_src};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (w_en) begin
                s_q <= s_d;
                c_q <= w_chunk[CW];
                v_q <= w_v_src;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (w_en) begin
                    a_q <= w_a_src[RW-1:CW];
                    b_q <= w_b_src[RW-1:CW];
                end
            end
        end else begin : g_tail
            // Carry into the MSB recovered from the MSB sum bit of this chunk's adder.
            logic w_msb_cin;
            logic ovf_q;
            logic zero_q;

            assign w_msb_cin = w_a_src[CW-1] ^ w_b_src[CW-1] ^ w_chunk[CW-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (w_en) begin
                    ovf_q  <= w_msb_cin ^ w_chunk[CW];
                    zero_q <= (s_d == '0);
                end
            end
        end
    end

    assign w_en          = ~g_stage[STAGES-1].v_q | bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_q;
    assign bus.zero      = g_stage[STAGES-1].g_tail.zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pipelined_addsub
// Brief   : scoreboard bench for pipelined_addsub against an arithmetic model
// Rev     : 1.0
// ----------------------------------------------------------------------------
module tb_pipelined_addsub;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus_m  ();
    pipelined_addsub_if #(.WIDTH(WIDTH)) bus_1  ();
    pipelined_addsub_if #(.WIDTH(WIDTH)) bus_16 ();

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut     (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(1))      u_dut_s1  (.clk(clk), .rst_n(rst_n), .bus(bus_1));
    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(16))     u_dut_s16 (.clk(clk), .rst_n(rst_n), .bus(bus_16));

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    res_t exp_q[$];
    res_t mon_exp;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cycle     = 0;
    int   n_pop     = 0;
    int   first_pop = -1;
    int   last_pop  = -1;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        int   ua, ub, ures, sa, sb, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ures   = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            ures   = ua + ub + int'(cin);
            sres   = sa + sb + int'(cin);
            r.cout = (ures > 65535);
        end
        r.sum  = ures[WIDTH-1:0];
        r.ovf  = (sres > 32767) || (sres < -32768);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus_m.out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got sum 0x%0h, expected no output", bus_m.sum);
            end else begin
                mon_exp = exp_q[0];
                check("sum",  bus_m.sum,  mon_exp.sum);
                check("cout", bus_m.cout, mon_exp.cout);
                check("ovf",  bus_m.ovf,  mon_exp.ovf);
                check("zero", bus_m.zero, mon_exp.zero);
                if (bus_m.out_ready) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                    if (first_pop < 0) first_pop = cycle;
                    last_pop = cycle;
                end
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        bus_m.a        = a;
        bus_m.b        = b;
        bus_m.cin      = cin;
        bus_m.sub      = sub;
        bus_m.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus_m.in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: in_ready got 0, expected 1");
    endtask

    task automatic latency(input string name, input int want);
        int lat = 0;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            if (bus_m.out_valid) begin
                lat = t;
                break;
            end
        end
        check(name, lat, want);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int n_acc;
        int lat1;
        int lat16;

        bus_m.in_valid  = 1'b0; bus_m.a  = '0; bus_m.b  = '0; bus_m.cin  = 1'b0; bus_m.sub  = 1'b0;
        bus_1.in_valid  = 1'b0; bus_1.a  = '0; bus_1.b  = '0; bus_1.cin  = 1'b0; bus_1.sub  = 1'b0;
        bus_16.in_valid = 1'b0; bus_16.a = '0; bus_16.b = '0; bus_16.cin = 1'b0; bus_16.sub = 1'b0;
        bus_m.out_ready = 1'b0;
        bus_1.out_ready = 1'b1;
        bus_16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus_m.out_valid, 0);
        check("rst_sum",       bus_m.sum,       0);
        check("rst_cout",      bus_m.cout,      0);
        check("rst_ovf",       bus_m.ovf,       0);
        check("rst_zero",      bus_m.zero,      0);
        check("rst_in_ready",  bus_m.in_ready,  1);
        rst_n = 1'b1;
        bus_m.out_ready = 1'b1;
        @(posedge clk);
        #1;

        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        bus_m.in_valid = 1'b0;
        latency("latency_first", STAGES);
        drain("drain_first");

        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drive(16'h1234, 16'h0000, 1'b1, 1'b0);
        drive(16'h0003, 16'h0005, 1'b0, 1'b1);
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        drive(16'h0005, 16'h0005, 1'b1, 1'b1);
        bus_m.in_valid = 1'b0;
        drain("drain_directed");

        base = n_pop;
        first_pop = -1;
        for (int i = 0; i < 100; i++)
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        bus_m.in_valid = 1'b0;
        drain("drain_burst");
        check("burst_count", n_pop - base, 100);
        check("burst_span",  last_pop - first_pop, 99);

        base  = n_pop;
        n_acc = 0;
        for (int i = 0; i < 300; i++) begin
            bus_m.out_ready = ($urandom_range(0, 1) == 1);
            bus_m.in_valid  = ($urandom_range(0, 3) != 0);
            bus_m.a   = WIDTH'($urandom);
            bus_m.b   = WIDTH'($urandom);
            bus_m.cin = 1'($urandom);
            bus_m.sub = 1'($urandom);
            @(negedge clk);
            if (bus_m.in_valid && bus_m.in_ready) begin
                exp_q.push_back(model(bus_m.a, bus_m.b, bus_m.cin, bus_m.sub));
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        bus_m.in_valid  = 1'b0;
        bus_m.out_ready = 1'b1;
        drain("drain_stall");
        check("stall_count", n_pop - base, n_acc);

        bus_m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        bus_m.in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus_m.out_valid) break;
        end
        check("pre_rst_valid", bus_m.out_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", bus_m.out_valid, 0);
        check("midrst_sum",       bus_m.sum,       0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_m.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", bus_m.out_valid, 0);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        bus_m.in_valid = 1'b0;
        latency("latency_after_rst", STAGES);
        drain("drain_after_rst");

        bus_1.a  = 16'hFFFF; bus_1.b  = 16'h0001; bus_1.in_valid  = 1'b1;
        bus_16.a = 16'hFFFF; bus_16.b = 16'h0001; bus_16.in_valid = 1'b1;
        @(negedge clk);
        check("s1_in_ready",  bus_1.in_ready,  1);
        check("s16_in_ready", bus_16.in_ready, 1);
        @(posedge clk);
        #1;
        bus_1.in_valid  = 1'b0;
        bus_16.in_valid = 1'b0;
        lat1  = 0;
        lat16 = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (lat1 == 0 && bus_1.out_valid) begin
                lat1 = t;
                check("s1_sum",  bus_1.sum,  16'h0000);
                check("s1_cout", bus_1.cout, 1);
                check("s1_zero", bus_1.zero, 1);
            end
            if (lat16 == 0 && bus_16.out_valid) begin
                lat16 = t;
                check("s16_sum",  bus_16.sum,  16'h0000);
                check("s16_cout", bus_16.cout, 1);
                check("s16_zero", bus_16.zero, 1);
            end
            if (lat1 != 0 && lat16 != 0) break;
        end
        check("s1_latency",  lat1,  1);
        check("s16_latency", lat16, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
